// File: rtl/ad9361_samp_pack.sv
// ad9361_samp_pack: buffers four gated I/Q channels in per-channel FIFOs and
// emits channel-tagged 32-bit words in round-robin bursts on a valid/ready
// stream. Word format: [31:30] channel, [29:24] seq, [23:12] I, [11:0] Q.
// Optional feature: define AD9361_SAMP_PACK_HEADER_EN to prefix every burst
// with a header word {8'hA5, 6'b0, channel, ts[15:0]}.
module ad9361_samp_pack #(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_0_in,
    input  logic [11:0] data_i0_in,
    input  logic [11:0] data_q0_in,
    input  logic        valid_1_in,
    input  logic [11:0] data_i1_in,
    input  logic [11:0] data_q1_in,
    input  logic        valid_2_in,
    input  logic [11:0] data_i2_in,
    input  logic [11:0] data_q2_in,
    input  logic        valid_3_in,
    input  logic [11:0] data_i3_in,
    input  logic [11:0] data_q3_in,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        ovf_clr,
    output logic [3:0]  ovf
);

    localparam int            FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int            PW        = FIFO_AW + 1;
    localparam logic [PW-1:0] FULL_CNT  = PW'(FIFO_DEPTH);
    localparam logic [7:0]    BURST_MAX = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_HDR   = 2'd2
    } state_t;

    // Channel inputs gathered into arrays so the per-channel logic is a loop
    logic [3:0]    in_valid;
    logic [11:0]   in_i [4];
    logic [11:0]   in_q [4];

    logic [5:0]    seq_q    [4];
    logic [29:0]   mem_q    [4][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] fill     [4];
    logic [3:0]    empty, full, wr_en, rd_en, ovf_evt;
    logic [3:0]    ovf_q, ovf_d;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [7:0]    bcnt_q, bcnt_d;
    logic          pick_valid;
    logic [1:0]    pick_ch, cand;
    logic          out_free, load_data, last_word;
    logic [29:0]   rd_word;

    logic          m_valid_q, m_last_q;
    logic [31:0]   m_data_q;

`ifdef AD9361_SAMP_PACK_HEADER_EN
    logic [15:0]   ts_q, hdr_ts_q;
    logic          load_hdr;
`endif

    assign in_valid = {valid_3_in, valid_2_in, valid_1_in, valid_0_in};
    assign in_i[0]  = data_i0_in;
    assign in_i[1]  = data_i1_in;
    assign in_i[2]  = data_i2_in;
    assign in_i[3]  = data_i3_in;
    assign in_q[0]  = data_q0_in;
    assign in_q[1]  = data_q1_in;
    assign in_q[2]  = data_q2_in;
    assign in_q[3]  = data_q3_in;

    // FIFO occupancy; full is judged before any read of the same cycle
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fill[k]    = wr_ptr_q[k] - rd_ptr_q[k];
            empty[k]   = (fill[k] == '0);
            full[k]    = (fill[k] == FULL_CNT);
            wr_en[k]   = in_valid[k] && !full[k];
            ovf_evt[k] = in_valid[k] && full[k];
        end
    end

    // Only the granted FIFO is ever read, and only when a data word is loaded
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_en[k] = load_data && (grant_q == 2'(k));
        end
    end

    assign rd_word  = mem_q[grant_q][rd_ptr_q[grant_q][FIFO_AW-1:0]];
    assign out_free = !m_valid_q || m_ready;
    assign ovf_d    = (ovf_clr ? 4'b0000 : ovf_q) | ovf_evt;

    // Sequence counters and FIFO pointers; seq advances even on dropped samples
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                seq_q[k]    <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (in_valid[k]) seq_q[k]    <= seq_q[k] + 6'd1;
                if (wr_en[k])    wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
                if (rd_en[k])    rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
            end
            ovf_q <= ovf_d;
        end
    end

    // FIFO storage: each word keeps the pre-increment seq value
    // NOTE: storage is deliberately not reset; the reset pointers mark every entry invalid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) mem_q[k][wr_ptr_q[k][FIFO_AW-1:0]] <= {seq_q[k], in_i[k], in_q[k]};
        end
    end

    // Round-robin search: first non-empty channel from the pointer upward, mod 4
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = ptr_q;
        cand       = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (!empty[cand]) begin
                pick_valid = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // FSM state, grant, pointer and burst counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state logic: grant in IDLE, stream the granted FIFO in BURST
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        load_data = 1'b0;
        last_word = 1'b0;
`ifdef AD9361_SAMP_PACK_HEADER_EN
        load_hdr  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_ch;
                    bcnt_d  = '0;
`ifdef AD9361_SAMP_PACK_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_BURST;
`endif
                end
            end
`ifdef AD9361_SAMP_PACK_HEADER_EN
            S_HDR: begin
                if (out_free) begin
                    load_hdr = 1'b1;
                    state_d  = S_BURST;
                end
            end
`endif
            S_BURST: begin
                // A write landing on the same edge as the final read does not extend the burst
                if (out_free) begin
                    load_data = 1'b1;
                    bcnt_d    = bcnt_q + 8'd1;
                    last_word = ((bcnt_q + 8'd1) == BURST_MAX) || (fill[grant_q] == PW'(1));
                    if (last_word) begin
                        ptr_d   = grant_q + 2'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef AD9361_SAMP_PACK_HEADER_EN
    // Free-running timestamp, captured into the header on the grant cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            hdr_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            if (state_q == S_IDLE && pick_valid) hdr_ts_q <= ts_q;
        end
    end
`endif

    // Output register: loads only when empty or drained this cycle, holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (load_data) begin
            m_valid_q <= 1'b1;
            m_last_q  <= last_word;
            m_data_q  <= {grant_q, rd_word};
`ifdef AD9361_SAMP_PACK_HEADER_EN
        end else if (load_hdr) begin
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            m_data_q  <= {8'hA5, 6'b0, grant_q, hdr_ts_q};
`endif
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ad9361_samp_pack.sv
// Self-checking bench for ad9361_samp_pack (default build, no header words).
// A queue-based model predicts the output stream every cycle; directed
// scenarios add hand-computed literal expectations on the accepted words.
module tb_ad9361_samp_pack;

    localparam int DEPTH = 16;
    localparam int BLEN  = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  vin   = '0;
    logic [11:0] di [4];
    logic [11:0] dq [4];
    logic        m_ready = 1'b1;
    logic        ovf_clr = 1'b0;
    logic        m_valid, m_last;
    logic [31:0] m_data;
    logic [3:0]  ovf;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ad9361_samp_pack #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_0_in (vin[0]),
        .data_i0_in (di[0]),
        .data_q0_in (dq[0]),
        .valid_1_in (vin[1]),
        .data_i1_in (di[1]),
        .data_q1_in (dq[1]),
        .valid_2_in (vin[2]),
        .data_i2_in (di[2]),
        .data_q2_in (dq[2]),
        .valid_3_in (vin[3]),
        .data_i3_in (di[3]),
        .data_q3_in (dq[3]),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .ovf_clr    (ovf_clr),
        .ovf        (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mq [$];      // all buffered words, channel in [31:30], arrival order
    bit          in_burst;
    int          g, ptr, bc;
    logic [5:0]  mseq [4];
    logic [3:0]  movf;
    bit          mv, ml;
    logic [31:0] md;
    logic [32:0] acc_q [$];   // accepted words {last, data}

    function automatic int ch_count(input int k);
        int c = 0;
        foreach (mq[i]) if (int'(mq[i][31:30]) == k) c++;
        return c;
    endfunction

    function automatic int ch_front(input int k);
        for (int i = 0; i < mq.size(); i++) if (int'(mq[i][31:30]) == k) return i;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        in_burst = 0; g = 0; ptr = 0; bc = 0;
        for (int k = 0; k < 4; k++) mseq[k] = '0;
        movf = '0; mv = 0; ml = 0; md = '0;
    endtask

    task automatic model_step();
        int          cnt [4];
        bit          free, ld, lst, found;
        logic [31:0] w;
        logic [3:0]  evt;
        int          idx;
        free = !mv || m_ready;
        for (int k = 0; k < 4; k++) cnt[k] = ch_count(k);
        ld = 0; lst = 0; w = '0; evt = '0; found = 0; idx = 0;
        if (in_burst) begin
            if (free) begin
                idx = ch_front(g);
                w   = mq[idx];
                lst = (bc + 1 == BLEN) || (cnt[g] == 1);
                mq.delete(idx);
                bc++;
                ld = 1;
                if (lst) begin
                    in_burst = 0;
                    ptr = (g + 1) % 4;
                end
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (!found && cnt[(ptr + o) % 4] != 0) begin
                    g = (ptr + o) % 4;
                    found = 1;
                end
            end
            if (found) begin
                in_burst = 1;
                bc = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (vin[k]) begin
                if (cnt[k] == DEPTH) evt[k] = 1'b1;
                else mq.push_back({2'(k), mseq[k], di[k], dq[k]});
                mseq[k] = mseq[k] + 6'd1;
            end
        end
        movf = (ovf_clr ? 4'b0000 : movf) | evt;
        if (ld) begin
            mv = 1; md = w; ml = lst;
        end else if (m_ready) begin
            mv = 0; ml = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare process: every cycle out of reset, on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", 32'(m_valid), 32'(mv));
            check("m_last", 32'(m_last), 32'(ml));
            check("ovf", 32'(ovf), 32'(movf));
            if (mv) check("m_data", m_data, md);
            if (m_valid && m_ready) acc_q.push_back({m_last, m_data});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vin   = '0;
        ticks(2);
        rst_n = 1'b1;
        acc_q.delete();
        tick();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            di[k] = '0;
            dq[k] = '0;
        end

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        tick();

        // Single ch2 sample: latency E+2, single-word burst
        vin[2] = 1'b1; di[2] = 12'h123; dq[2] = 12'hABC;
        tick();
        vin = '0;
        check("lat_e0", 32'(m_valid), 32'd0);
        tick();
        check("lat_e1", 32'(m_valid), 32'd0);
        tick();
        check("lat_e2_valid", 32'(m_valid), 32'd1);
        check("lat_e2_data", m_data, 32'h80123ABC);
        check("lat_e2_last", 32'(m_last), 32'd1);
        tick();
        check("lat_e3_valid", 32'(m_valid), 32'd0);
        ticks(4);
        check("t1_count", 32'(acc_q.size()), 32'd1);

        // Ch0 continuous 20 samples: bursts 8, 8, 4
        acc_q.delete();
        vin[0] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            di[0] = 12'(n * 3 + 1);
            dq[0] = 12'(n);
            tick();
        end
        vin = '0;
        ticks(20);
        check("t2_count", 32'(acc_q.size()), 32'd20);
        for (int n = 0; n < acc_q.size() && n < 20; n++) begin
            check("t2_ch", 32'(acc_q[n][31:30]), 32'd0);
            check("t2_seq", 32'(acc_q[n][29:24]), 32'(n));
            check("t2_last", 32'(acc_q[n][32]), 32'((n == 7 || n == 15 || n == 19) ? 1 : 0));
        end
        check("t2_ovf", 32'(ovf), 32'd0);

        // All four channels at once, twice: order ch0..ch3 both times
        do_reset();
        for (int r = 0; r < 2; r++) begin
            vin = 4'hF;
            for (int k = 0; k < 4; k++) begin
                di[k] = 12'h100 + 12'(k);
                dq[k] = 12'h200 + 12'(k);
            end
            tick();
            vin = '0;
            ticks(12);
        end
        check("t3_count", 32'(acc_q.size()), 32'd8);
        for (int n = 0; n < acc_q.size() && n < 8; n++) begin
            check("t3_word", acc_q[n][31:0],
                  {2'(n % 4), 6'(n / 4), 12'h100 + 12'(n % 4), 12'h200 + 12'(n % 4)});
            check("t3_last", 32'(acc_q[n][32]), 32'd1);
        end

        // Overflow on ch1 while the output is stalled; clear colliding with a new drop
        do_reset();
        m_ready = 1'b0;
        vin[0] = 1'b1; di[0] = 12'h0AA; dq[0] = 12'h055;
        tick();
        vin = '0;
        ticks(4);
        check("t4_held_valid", 32'(m_valid), 32'd1);
        vin[1] = 1'b1;
        for (int n = 0; n < 18; n++) begin
            di[1] = 12'(n);
            dq[1] = 12'hF00 | 12'(n);
            ovf_clr = (n == 17);
            tick();
        end
        vin = '0;
        ovf_clr = 1'b0;
        check("t4_ovf_set", 32'(ovf), 32'h2);
        m_ready = 1'b1;
        ticks(30);
        check("t4_count", 32'(acc_q.size()), 32'd17);
        if (acc_q.size() >= 17) begin
            check("t4_first", acc_q[0][31:0], 32'h000AA055);
            for (int n = 0; n < 16; n++) begin
                check("t4_ch", 32'(acc_q[1 + n][31:30]), 32'd1);
                check("t4_seq", 32'(acc_q[1 + n][29:24]), 32'(n));
                check("t4_last", 32'(acc_q[1 + n][32]), 32'((n == 7 || n == 15) ? 1 : 0));
            end
        end
        vin[1] = 1'b1; di[1] = 12'h777; dq[1] = 12'h888;
        tick();
        vin = '0;
        ticks(5);
        check("t4_count2", 32'(acc_q.size()), 32'd18);
        if (acc_q.size() >= 18) check("t4_seq_gap", 32'(acc_q[17][29:24]), 32'd18);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(ovf), 32'd0);

        // m_ready toggling mid-burst on ch3
        do_reset();
        for (int c = 0; c < 40; c++) begin
            m_ready = c[0];
            vin[3]  = (c < 10);
            di[3]   = 12'(c + 50);
            dq[3]   = 12'(c * 7);
            tick();
        end
        vin = '0;
        m_ready = 1'b1;
        ticks(10);
        check("t5_count", 32'(acc_q.size()), 32'd10);
        for (int n = 0; n < acc_q.size() && n < 10; n++) begin
            check("t5_seq", 32'(acc_q[n][29:24]), 32'(n));
            check("t5_last", 32'(acc_q[n][32]), 32'((n == 7 || n == 9) ? 1 : 0));
        end

        // Asynchronous reset mid-burst
        do_reset();
        m_ready = 1'b1;
        vin[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            di[0] = 12'(n + 9);
            dq[0] = 12'(n + 90);
            tick();
        end
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        check("t6_wait_valid", 32'(m_valid), 32'd1);
        #3 rst_n = 1'b0;
        vin = '0;
        #1;
        check("t6_async_valid", 32'(m_valid), 32'd0);
        check("t6_async_data", m_data, 32'd0);
        check("t6_async_last", 32'(m_last), 32'd0);
        acc_q.delete();
        ticks(2);
        rst_n = 1'b1;
        ticks(10);
        check("t6_no_stale", 32'(acc_q.size()), 32'd0);
        vin[0] = 1'b1; di[0] = 12'h321; dq[0] = 12'h654;
        tick();
        vin = '0;
        ticks(5);
        check("t6_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) check("t6_word", acc_q[0][31:0], 32'h00321654);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
